clk_cfg_apb_bridge: RTL and testbench
=====================================

Name: clk_cfg_apb_bridge

Overview:
- APB slave converting CPU register accesses into the req/ack configuration handshakes of the FPGA clock generator.
- Serves three targets: soc, per and cluster. Sits directly upstream of the clock generator, on the SoC peripheral APB bus.
- Also exposes a local status register with the live lock bits and sticky lock-lost flags.

Parameters:
TIMEOUT_CYCLES, 64, REQ cycles without ack before the access aborts with PSLVERR; legal range 2..1023.
APB_ADDR_WIDTH, 12, PADDR width; only PADDR[5:2] is decoded.

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous, active-high reset
paddr_i  in  APB_ADDR_WIDTH  APB address
psel_i  in  1  APB select
penable_i  in  1  APB enable
pwrite_i  in  1  APB write
pwdata_i  in  32  APB write data
prdata_o  out  32  APB read data
pready_o  out  1  APB ready
pslverr_o  out  1  APB error
cfg_req_o  out  3  request per target: [0] soc, [1] per, [2] cluster
cfg_ack_i  in  3  ack per target
cfg_add_o  out  2  register address, shared by all targets
cfg_data_o  out  32  write data, shared
cfg_wrn_o  out  1  1 = read, 0 = write, shared
cfg_r_data_i  in  3x32  read data per target, packed as [95:64] cluster, [63:32] per, [31:0] soc
cfg_lock_i  in  3  lock per target

Behaviour:
- Clocking and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset state: FSM in IDLE; cfg_req_o=0, cfg_add_o=0, cfg_data_o=0, cfg_wrn_o=1; prdata_o=0, pready_o=0, pslverr_o=0; sticky flags=0; timeout counter=0.
- Address decode: PADDR[5:4] selects the target (0 soc, 1 per, 2 cluster, 3 local status). PADDR[3:2] drives cfg_add_o.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - On psel_i=1 and penable_i=0 with target 0..2: register add, data and wrn=~pwrite_i, then go to REQ.
  - On target 3: stay in IDLE and answer the access phase combinationally with pready_o=1.
    - Read returns {25'b0, sticky[2:0], 1'b0, lock[2:0]}: bits[2:0] live lock, bits[6:4] sticky.
    - Write clears sticky bits whose pwdata_i[6:4] bit is 1 (W1C). pslverr_o=0.
- REQ:
  - cfg_req_o[target]=1; all other req bits are 0. pready_o=0.
  - Add, data and wrn stay stable while req is high.
  - Ack is sampled on the clock edge; it may arrive in the same cycle req rises.
  - When cfg_ack_i[target]=1: capture cfg_r_data_i[target] into prdata_o (reads only; writes give prdata_o=0), then go to DONE.
  - The counter increments each REQ cycle. At TIMEOUT_CYCLES-1 without ack: go to DONE with the error flag set and prdata_o=32'hDEAD_C1C0.
  - Acks on non-selected targets are ignored.
- DONE: pready_o=1 and pslverr_o=error flag for exactly one cycle; req=0. Then go to IDLE, clearing the counter and error flag.
- Latency: with an immediate ack, the setup phase is T0, REQ is T1 and DONE is T2, giving exactly one wait state.
- Sticky flags:
  - sticky[i] sets on a 1→0 transition of cfg_lock_i[i], detected via a registered copy.
  - If a set and a W1C clear happen in the same cycle, set wins.
- psel_i dropping mid-transaction: the FSM still completes the handshake and DONE is emitted. The response is lost; no hang.
- New setup phase while not in IDLE: ignored (APB forbids it).
- Reset mid-REQ: req drops at the reset edge; no ack is awaited.

Decomposition:
- Package clk_cfg_pkg: target enum (TGT_SOC, TGT_PER, TGT_CLUSTER, TGT_STATUS), FSM state enum, status bit positions, timeout read pattern.
- One sub-module, clk_cfg_lock_monitor: lock edge detector, sticky register and W1C logic.

Test Plan:
1. Read soc reg 0 (PADDR=0x000) with the model acking immediately and r_data=32'h00A10099 → one wait state, prdata=32'h00A10099, pslverr=0, cfg_wrn_o=1 while req is high.
2. Write 32'h1234_5678 to per reg 2 (PADDR=0x018) with ack delayed 5 cycles → req[1] high for 6 cycles with add=2 and data stable, then pready for 1 cycle, pslverr=0.
3. Access cluster (PADDR=0x020) with ack never asserted and TIMEOUT_CYCLES=64 → req high for 64 cycles, then pready=1, pslverr=1, prdata=32'hDEAD_C1C0; FSM returns to IDLE.
4. Drop cfg_lock_i[0] then restore it; read PADDR=0x030 → 0x17. Write 0x10, then read → 0x07.
5. Assert rst_i for one cycle during REQ → next cycle cfg_req_o=0 and FSM in IDLE; a following read completes normally.
6. Ack on per (cfg_ack_i=3'b010) during a soc request → ignored; completes only on cfg_ack_i[0].

Source files
------------

// File: rtl/clk_cfg_pkg.sv
// Shared types and constants for the clock-generator configuration APB bridge.
package clk_cfg_pkg;

  typedef enum logic [1:0] {
    TGT_SOC     = 2'd0,
    TGT_PER     = 2'd1,
    TGT_CLUSTER = 2'd2,
    TGT_STATUS  = 2'd3
  } target_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned NUM_TGT           = 3;
  localparam int unsigned CNT_W             = 10;
  localparam int unsigned STATUS_LOCK_LSB   = 0;
  localparam int unsigned STATUS_STICKY_LSB = 4;
  localparam logic [31:0] TIMEOUT_RDATA     = 32'hDEAD_C1C0;

  function automatic logic [31:0] status_word(input logic [NUM_TGT-1:0] sticky,
                                              input logic [NUM_TGT-1:0] lock);
    logic [31:0] w;
    w = '0;
    w[STATUS_LOCK_LSB +: NUM_TGT]   = lock;
    w[STATUS_STICKY_LSB +: NUM_TGT] = sticky;
    return w;
  endfunction

  function automatic logic [NUM_TGT-1:0] req_onehot(input target_e t);
    logic [NUM_TGT-1:0] r;
    case (t)
      TGT_SOC:     r = 3'b001;
      TGT_PER:     r = 3'b010;
      TGT_CLUSTER: r = 3'b100;
      default:     r = 3'b000;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] pick_rdata(input logic [3*32-1:0] d, input target_e t);
    logic [31:0] r;
    case (t)
      TGT_SOC:     r = d[31:0];
      TGT_PER:     r = d[63:32];
      TGT_CLUSTER: r = d[95:64];
      default:     r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/clk_cfg_lock_monitor.sv
// Detects falling edges of each lock input and keeps sticky lock-lost flags
// with write-one-to-clear; a new loss wins over a simultaneous clear.
module clk_cfg_lock_monitor
  import clk_cfg_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_TGT-1:0] lock,
  input  logic [NUM_TGT-1:0] clr,
  output logic [NUM_TGT-1:0] sticky
);

  logic [NUM_TGT-1:0] lock_q;
  logic [NUM_TGT-1:0] fall;

  assign fall = lock_q & ~lock;

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q <= '0;
      sticky <= '0;
    end else begin
      lock_q <= lock;
      sticky <= (sticky & ~clr) | fall;
    end
  end

endmodule

// File: rtl/clk_cfg_apb_bridge.sv
// APB slave turning CPU accesses into req/ack configuration handshakes towards the
// clock generator's soc/per/cluster targets, plus a local lock status register.
module clk_cfg_apb_bridge
  import clk_cfg_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned APB_ADDR_WIDTH = 12
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
  input  logic                      psel_i,
  input  logic                      penable_i,
  input  logic                      pwrite_i,
  input  logic [31:0]               pwdata_i,
  output logic [31:0]               prdata_o,
  output logic                      pready_o,
  output logic                      pslverr_o,
  output logic [NUM_TGT-1:0]        cfg_req_o,
  input  logic [NUM_TGT-1:0]        cfg_ack_i,
  output logic [1:0]                cfg_add_o,
  output logic [31:0]               cfg_data_o,
  output logic                      cfg_wrn_o,
  input  logic [NUM_TGT*32-1:0]     cfg_r_data_i,
  input  logic [NUM_TGT-1:0]        cfg_lock_i,
  output state_e                    dbg_state
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e             state_q;
  target_e            tgt_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [31:0]        prdata_q;
  logic               pready_q;
  logic               pslverr_q;

  target_e            addr_tgt;
  logic               setup;
  logic               status_access;
  logic               ack_hit;
  logic [NUM_TGT-1:0] sticky;
  logic [NUM_TGT-1:0] clr;
  logic               unused_paddr;

  assign addr_tgt      = target_e'(paddr_i[5:4]);
  assign setup         = psel_i & ~penable_i;
  assign status_access = (state_q == ST_IDLE) & psel_i & penable_i & (addr_tgt == TGT_STATUS);
  assign clr           = (status_access & pwrite_i) ? pwdata_i[STATUS_STICKY_LSB +: NUM_TGT] : '0;
  assign unused_paddr  = ^{paddr_i[APB_ADDR_WIDTH-1:6], paddr_i[1:0]};

  // Handshake: cfg_req_o stays high with add/data/wrn frozen until the selected
  // target's ack is sampled high on a clock edge; acks of other targets are ignored.
  assign ack_hit = |(cfg_ack_i & cfg_req_o);

  clk_cfg_lock_monitor u_lock_monitor (
    .clk    (clk_i),
    .rst    (rst_i),
    .lock   (cfg_lock_i),
    .clr    (clr),
    .sticky (sticky)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      tgt_q      <= TGT_SOC;
      cnt_q      <= '0;
      cfg_req_o  <= '0;
      cfg_add_o  <= '0;
      cfg_data_o <= '0;
      cfg_wrn_o  <= 1'b1;
      prdata_q   <= '0;
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (setup && addr_tgt != TGT_STATUS) begin
            tgt_q      <= addr_tgt;
            cfg_add_o  <= paddr_i[3:2];
            cfg_data_o <= pwdata_i;
            cfg_wrn_o  <= ~pwrite_i;
            cfg_req_o  <= req_onehot(addr_tgt);
            state_q    <= ST_REQ;
          end
        end
        ST_REQ: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (ack_hit) begin
            prdata_q  <= cfg_wrn_o ? pick_rdata(cfg_r_data_i, tgt_q) : '0;
            cfg_req_o <= '0;
            pready_q  <= 1'b1;
            pslverr_q <= 1'b0;
            state_q   <= ST_DONE;
          end else if (cnt_q == CNT_LAST) begin
            prdata_q  <= TIMEOUT_RDATA;
            cfg_req_o <= '0;
            pready_q  <= 1'b1;
            pslverr_q <= 1'b1;
            state_q   <= ST_DONE;
          end
        end
        ST_DONE: begin
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          cnt_q     <= '0;
          state_q   <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // The status register answers in the access phase without a wait state.
  assign prdata_o  = status_access ? status_word(sticky, cfg_lock_i) : prdata_q;
  assign pready_o  = pready_q | status_access;
  assign pslverr_o = pslverr_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_clk_cfg_apb_bridge.sv
// Directed bench for clk_cfg_apb_bridge: per-cycle expected timeline queue plus literal checks.
module tb_clk_cfg_apb_bridge;
  import clk_cfg_pkg::*;

  localparam int TO    = 64;
  localparam int NEVER = 1000;

  typedef struct packed {
    logic [2:0]  req;
    logic [1:0]  add;
    logic [31:0] data;
    logic        wrn;
    logic        pready;
    logic        pslverr;
    logic        chk_prdata;
    logic [31:0] prdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] paddr;
  logic        psel, penable, pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic [2:0]  cfg_req, cfg_ack;
  logic [1:0]  cfg_add;
  logic [31:0] cfg_data;
  logic        cfg_wrn;
  logic [31:0] soc_rd, per_rd, cl_rd;
  logic [95:0] cfg_r_data;
  logic [2:0]  cfg_lock;
  state_e      dbg_state;

  int         n_cmp = 0;
  int         n_err = 0;
  int         req_cycles = 0;
  int         ack_delay = NEVER;
  int         req_age = 0;
  logic [2:0] spur_ack = 3'b000;
  logic [2:0] model_sticky = 3'b000;
  logic       chk_en = 1'b0;
  exp_t       exp_q[$];

  assign cfg_r_data = {cl_rd, per_rd, soc_rd};

  clk_cfg_apb_bridge #(.TIMEOUT_CYCLES(TO), .APB_ADDR_WIDTH(12)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .paddr_i      (paddr),
    .psel_i       (psel),
    .penable_i    (penable),
    .pwrite_i     (pwrite),
    .pwdata_i     (pwdata),
    .prdata_o     (prdata),
    .pready_o     (pready),
    .pslverr_o    (pslverr),
    .cfg_req_o    (cfg_req),
    .cfg_ack_i    (cfg_ack),
    .cfg_add_o    (cfg_add),
    .cfg_data_o   (cfg_data),
    .cfg_wrn_o    (cfg_wrn),
    .cfg_r_data_i (cfg_r_data),
    .cfg_lock_i   (cfg_lock),
    .dbg_state    (dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: run exceeded 100000 ns");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] target_rdata(input logic [1:0] t);
    case (t)
      2'd0:    return soc_rd;
      2'd1:    return per_rd;
      default: return cl_rd;
    endcase
  endfunction

  // Clock-generator target model: acks the raised req after ack_delay cycles
  initial begin : responder
    cfg_ack = 3'b000;
    forever begin
      @(posedge clk); #1;
      if (cfg_req != 3'b000) begin
        cfg_ack = ((req_age == ack_delay) ? cfg_req : 3'b000) | spur_ack;
        req_age++;
      end else begin
        cfg_ack = 3'b000;
        req_age = 0;
      end
    end
  end

  initial begin : req_counter
    forever begin
      @(negedge clk);
      if (cfg_req != 3'b000) req_cycles++;
    end
  end

  // Scoreboard: one expected entry per cycle, idle when the queue is empty
  initial begin : compare
    exp_t e;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = '0;
        check("cyc_req", 32'(cfg_req), 32'(e.req));
        check("cyc_pready", 32'(pready), 32'(e.pready));
        check("cyc_pslverr", 32'(pslverr), 32'(e.pslverr));
        if (e.req != 3'b000) begin
          check("cyc_add", 32'(cfg_add), 32'(e.add));
          check("cyc_data", cfg_data, e.data);
          check("cyc_wrn", 32'(cfg_wrn), 32'(e.wrn));
        end
        if (e.pready && e.chk_prdata) check("cyc_prdata", prdata, e.prdata);
      end
    end
  end

  // APB master transfer; drop lowers lock bits at the start of the access phase
  task automatic apb_xfer(input logic [11:0] addr, input logic wr, input logic [31:0] wdata,
                          input int delay, input logic [2:0] drop,
                          output logic [31:0] rdata, output logic err, output int waits);
    logic [1:0] tgt;
    int         n;
    int         total;
    logic       tmo;
    exp_t       e;
    tgt = addr[5:4];
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = wdata; ack_delay = delay;
    e = '0;
    exp_q.push_back(e);
    if (tgt != 2'd3) begin
      tmo = (delay >= TO);
      n   = tmo ? TO : delay + 1;
      for (int k = 0; k < n; k++) begin
        e = '0;
        e.req = 3'b001 << tgt; e.add = addr[3:2]; e.data = wdata; e.wrn = ~wr;
        exp_q.push_back(e);
      end
      e = '0;
      e.pready = 1'b1; e.pslverr = tmo; e.chk_prdata = 1'b1;
      if (tmo) e.prdata = 32'hDEAD_C1C0;
      else if (wr) e.prdata = 32'h0;
      else e.prdata = target_rdata(tgt);
      exp_q.push_back(e);
      total = n + 1;
    end else begin
      e = '0;
      e.pready = 1'b1; e.chk_prdata = ~wr; e.prdata = {25'b0, model_sticky, 1'b0, cfg_lock};
      exp_q.push_back(e);
      total = 1;
    end
    @(posedge clk); #1;
    penable = 1'b1;
    if (tgt == 2'd3 && wr) model_sticky = model_sticky & ~wdata[6:4];
    model_sticky = model_sticky | (drop & cfg_lock);
    cfg_lock = cfg_lock & ~drop;
    waits = -1; rdata = '0; err = 1'b0;
    for (int c = 1; c <= total; c++) begin
      @(negedge clk);
      if (pready === 1'b1 && waits < 0) begin
        waits = c - 1; rdata = prdata; err = pslverr;
      end
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic lock_pulse(input logic [2:0] m);
    @(posedge clk); #1;
    model_sticky = model_sticky | (m & cfg_lock);
    cfg_lock = cfg_lock & ~m;
    @(posedge clk); #1;
    cfg_lock = cfg_lock | m;
  endtask

  initial begin : main
    logic [31:0] rd;
    logic        er;
    int          w;
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    cfg_lock = 3'b111;
    soc_rd = 32'h00A1_0099; per_rd = 32'hCAFE_F00D; cl_rd = 32'h0C10_5E7A;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_req", 32'(cfg_req), 32'h0);
    check("rst_add", 32'(cfg_add), 32'h0);
    check("rst_data", cfg_data, 32'h0);
    check("rst_wrn", 32'(cfg_wrn), 32'h1);
    check("rst_prdata", prdata, 32'h0);
    check("rst_pready", 32'(pready), 32'h0);
    check("rst_pslverr", 32'(pslverr), 32'h0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(posedge clk); #1;
    chk_en = 1'b1;

    // Immediate-ack soc read: one wait state
    req_cycles = 0;
    apb_xfer(12'h000, 1'b0, 32'h0, 0, 3'b000, rd, er, w);
    check("t1_prdata", rd, 32'h00A1_0099);
    check("t1_pslverr", 32'(er), 32'h0);
    check("t1_waits", 32'(w), 32'd1);
    check("t1_req_cycles", 32'(req_cycles), 32'd1);

    // per write, ack after 5 cycles
    req_cycles = 0;
    apb_xfer(12'h018, 1'b1, 32'h1234_5678, 5, 3'b000, rd, er, w);
    check("t2_req_cycles", 32'(req_cycles), 32'd6);
    check("t2_waits", 32'(w), 32'd6);
    check("t2_pslverr", 32'(er), 32'h0);

    // cluster timeout
    req_cycles = 0;
    apb_xfer(12'h020, 1'b0, 32'h0, NEVER, 3'b000, rd, er, w);
    check("t3_req_cycles", 32'(req_cycles), 32'd64);
    check("t3_pslverr", 32'(er), 32'h1);
    check("t3_prdata", rd, 32'hDEAD_C1C0);
    @(negedge clk);
    check("t3_state_idle", 32'(dbg_state), 32'(ST_IDLE));

    // cluster write to reg 3, short delay
    apb_xfer(12'h02C, 1'b1, 32'hA5A5_0F0F, 2, 3'b000, rd, er, w);
    check("t3b_waits", 32'(w), 32'd3);

    // Lock loss and W1C
    lock_pulse(3'b001);
    apb_xfer(12'h030, 1'b0, 32'h0, 0, 3'b000, rd, er, w);
    check("t4_status_sticky", rd, 32'h17);
    check("t4_status_waits", 32'(w), 32'd0);
    apb_xfer(12'h030, 1'b1, 32'h10, 0, 3'b000, rd, er, w);
    check("t4_w1c_pslverr", 32'(er), 32'h0);
    apb_xfer(12'h030, 1'b0, 32'h0, 0, 3'b000, rd, er, w);
    check("t4_status_cleared", rd, 32'h07);

    // Lock loss coinciding with a clear of the same bit: set wins
    apb_xfer(12'h030, 1'b1, 32'h20, 0, 3'b010, rd, er, w);
    apb_xfer(12'h030, 1'b0, 32'h0, 0, 3'b000, rd, er, w);
    check("t4b_set_wins", rd, 32'h25);
    @(posedge clk); #1;
    cfg_lock = cfg_lock | 3'b010;
    apb_xfer(12'h030, 1'b1, 32'h20, 0, 3'b000, rd, er, w);
    apb_xfer(12'h030, 1'b0, 32'h0, 0, 3'b000, rd, er, w);
    check("t4b_cleared", rd, 32'h07);

    // Reset in the middle of a request
    chk_en = 1'b0;
    ack_delay = NEVER;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; paddr = 12'h004; pwrite = 1'b0; pwdata = '0;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("t5_req_before_rst", 32'(cfg_req), 32'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; psel = 1'b0; penable = 1'b0;
    model_sticky = 3'b000;
    @(negedge clk);
    check("t5_req_after_rst", 32'(cfg_req), 32'h0);
    check("t5_state_after_rst", 32'(dbg_state), 32'(ST_IDLE));
    check("t5_pready_after_rst", 32'(pready), 32'h0);
    @(posedge clk); #1;
    chk_en = 1'b1;
    apb_xfer(12'h014, 1'b0, 32'h0, 2, 3'b000, rd, er, w);
    check("t5_read_after_rst", rd, 32'hCAFE_F00D);
    check("t5_waits_after_rst", 32'(w), 32'd3);

    // Stray per ack during a soc request
    spur_ack = 3'b010;
    req_cycles = 0;
    apb_xfer(12'h00C, 1'b0, 32'h0, 3, 3'b000, rd, er, w);
    spur_ack = 3'b000;
    check("t6_req_cycles", 32'(req_cycles), 32'd4);
    check("t6_prdata", rd, 32'h00A1_0099);
    check("t6_waits", 32'(w), 32'd4);

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
